// File: rtl/bp_nonsynth_late_wb_scoreboard_pkg.sv
// Shared types for the late-writeback scoreboard: processor configs, error
// codes and small helpers used by the top level.
package bp_nonsynth_late_wb_scoreboard_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg = 2'd0
    } bp_params_e;

    typedef enum logic [1:0] {
        e_sb_none      = 2'd0,
        e_sb_underflow = 2'd1,
        e_sb_overflow  = 2'd2,
        e_sb_timeout   = 2'd3
    } bp_nonsynth_sb_err_e;

    localparam int unsigned sb_reg_addr_width_lp = 5;

    // Architectural registers per file for a given configuration
    function automatic int unsigned sb_num_regs(input bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 32;
            default:          return 32;
        endcase
    endfunction

    // Lowest set bit index, so the lowest-numbered register wins a tie
    function automatic logic [sb_reg_addr_width_lp-1:0] sb_lowest_idx(input logic [31:0] v);
        logic [sb_reg_addr_width_lp-1:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = sb_reg_addr_width_lp'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bp_nonsynth_sb_counter.sv
// Saturating up/down counter for one register's outstanding late writebacks.
// Simultaneous up and down cancel; errors flag the saturated direction.
module bp_nonsynth_sb_counter #(
    parameter int unsigned width_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o,
    output logic               underflow_o,
    output logic               overflow_o
);

    localparam logic [width_p-1:0] max_lp = '1;

    logic up_only, down_only;

    assign up_only     = up_i & ~down_i;
    assign down_only   = down_i & ~up_i;
    assign underflow_o = down_only & (count_o == '0);
    assign overflow_o  = up_only & (count_o == max_lp);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= '0;
        end else if (up_only & ~overflow_o) begin
            count_o <= count_o + width_p'(1);
        end else if (down_only & ~underflow_o) begin
            count_o <= count_o - width_p'(1);
        end
    end

endmodule

// File: rtl/bp_nonsynth_late_wb_scoreboard.sv
// Tracks outstanding late int/FP writebacks per register and flags underflow,
// overflow and timeout ahead of the cosim commit/writeback aligner.
module bp_nonsynth_late_wb_scoreboard
    import bp_nonsynth_late_wb_scoreboard_pkg::*;
#(
    parameter bp_params_e  bp_params_p = e_bp_default_cfg,
    parameter int unsigned timeout_p   = 4096,
    parameter int unsigned cnt_width_p = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        freeze_i,
    input  logic        commit_v_i,
    input  logic        commit_late_iwb_i,
    input  logic        commit_late_fwb_i,
    input  logic [4:0]  commit_rd_addr_i,
    input  logic        iwb_v_i,
    input  logic        iwb_late_i,
    input  logic [4:0]  iwb_addr_i,
    input  logic        fwb_v_i,
    input  logic        fwb_late_i,
    input  logic [4:0]  fwb_addr_i,
    output logic [31:0] ipending_o,
    output logic [31:0] fpending_o,
    output logic        idle_o,
    output logic        error_v_o,
    output logic [1:0]  error_code_o,
    output logic [5:0]  error_addr_o
);

    localparam int unsigned num_regs_lp  = sb_num_regs(bp_params_p);
    localparam int unsigned age_width_lp = $clog2(timeout_p + 1);
    localparam logic [age_width_lp-1:0] timeout_lp = age_width_lp'(timeout_p);

    logic                   sb_clear;
    logic [num_regs_lp-1:0] iinc, idec, finc, fdec;
    logic [num_regs_lp-1:0] iunder, iover, funder, fover;
    logic [cnt_width_p-1:0] icnt [num_regs_lp];
    logic [cnt_width_p-1:0] fcnt [num_regs_lp];

    assign sb_clear = reset_i | freeze_i;

    // Decode commit/writeback events into per-register up/down strobes
    always_comb begin
        iinc = '0;
        idec = '0;
        finc = '0;
        fdec = '0;
        iinc[commit_rd_addr_i] = commit_v_i & commit_late_iwb_i;
        finc[commit_rd_addr_i] = commit_v_i & commit_late_fwb_i;
        idec[iwb_addr_i]       = iwb_v_i & iwb_late_i;
        fdec[fwb_addr_i]       = fwb_v_i & fwb_late_i;
        // x0 is hardwired zero and never owes a writeback
        iinc[0] = 1'b0;
        idec[0] = 1'b0;
    end

    for (genvar i = 0; i < num_regs_lp; i++) begin : g_cnt
        bp_nonsynth_sb_counter #(.width_p(cnt_width_p)) u_icnt (
            .clk_i       (clk_i),
            .reset_i     (sb_clear),
            .up_i        (iinc[i]),
            .down_i      (idec[i]),
            .count_o     (icnt[i]),
            .underflow_o (iunder[i]),
            .overflow_o  (iover[i])
        );

        bp_nonsynth_sb_counter #(.width_p(cnt_width_p)) u_fcnt (
            .clk_i       (clk_i),
            .reset_i     (sb_clear),
            .up_i        (finc[i]),
            .down_i      (fdec[i]),
            .count_o     (fcnt[i]),
            .underflow_o (funder[i]),
            .overflow_o  (fover[i])
        );

        assign ipending_o[i] = |icnt[i];
        assign fpending_o[i] = |fcnt[i];
    end

    assign idle_o = ~(|ipending_o) & ~(|fpending_o);

    // Age of the oldest stretch without writeback progress
    logic [age_width_lp-1:0] age_q, age_n;
    logic                    age_clear_c, timeout_c;

    assign age_clear_c = idle_o | (iwb_v_i & iwb_late_i) | (fwb_v_i & fwb_late_i);

    always_comb begin
        age_n = age_q;
        if (age_clear_c) begin
            age_n = '0;
        end else if (age_q != timeout_lp) begin
            age_n = age_q + age_width_lp'(1);
        end
    end

    assign timeout_c = (age_n == timeout_lp);

    // Same-cycle priority: underflow, overflow, timeout; int ahead of FP
    logic       err_hit;
    logic [1:0] err_code_n;
    logic [5:0] err_addr_n;

    always_comb begin
        err_hit    = 1'b1;
        err_code_n = e_sb_none;
        err_addr_n = '0;
        if (|iunder) begin
            err_code_n = e_sb_underflow;
            err_addr_n = {1'b0, sb_lowest_idx(iunder)};
        end else if (|funder) begin
            err_code_n = e_sb_underflow;
            err_addr_n = {1'b1, sb_lowest_idx(funder)};
        end else if (|iover) begin
            err_code_n = e_sb_overflow;
            err_addr_n = {1'b0, sb_lowest_idx(iover)};
        end else if (|fover) begin
            err_code_n = e_sb_overflow;
            err_addr_n = {1'b1, sb_lowest_idx(fover)};
        end else if (timeout_c) begin
            err_code_n = e_sb_timeout;
        end else begin
            err_hit = 1'b0;
        end
    end

    // Age counter and sticky first-error capture
    always_ff @(posedge clk_i) begin
        if (sb_clear) begin
            age_q        <= '0;
            error_v_o    <= 1'b0;
            error_code_o <= '0;
            error_addr_o <= '0;
        end else begin
            age_q <= age_n;
            if (~error_v_o & err_hit) begin
                error_v_o    <= 1'b1;
                error_code_o <= err_code_n;
                error_addr_o <= err_addr_n;
            end
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_late_wb_scoreboard.sv
// Directed bench for the late-writeback scoreboard with timeout_p=16, cnt_width_p=3.
module tb_bp_nonsynth_late_wb_scoreboard;

    logic        clk_i = 1'b0;
    logic        reset_i, freeze_i;
    logic        commit_v_i, commit_late_iwb_i, commit_late_fwb_i;
    logic [4:0]  commit_rd_addr_i;
    logic        iwb_v_i, iwb_late_i, fwb_v_i, fwb_late_i;
    logic [4:0]  iwb_addr_i, fwb_addr_i;
    logic [31:0] ipending_o, fpending_o;
    logic        idle_o, error_v_o;
    logic [1:0]  error_code_o;
    logic [5:0]  error_addr_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    bp_nonsynth_late_wb_scoreboard #(
        .timeout_p   (16),
        .cnt_width_p (3)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .freeze_i          (freeze_i),
        .commit_v_i        (commit_v_i),
        .commit_late_iwb_i (commit_late_iwb_i),
        .commit_late_fwb_i (commit_late_fwb_i),
        .commit_rd_addr_i  (commit_rd_addr_i),
        .iwb_v_i           (iwb_v_i),
        .iwb_late_i        (iwb_late_i),
        .iwb_addr_i        (iwb_addr_i),
        .fwb_v_i           (fwb_v_i),
        .fwb_late_i        (fwb_late_i),
        .fwb_addr_i        (fwb_addr_i),
        .ipending_o        (ipending_o),
        .fpending_o        (fpending_o),
        .idle_o            (idle_o),
        .error_v_o         (error_v_o),
        .error_code_o      (error_code_o),
        .error_addr_o      (error_addr_o)
    );

    task automatic idle_inputs();
        commit_v_i = 0; commit_late_iwb_i = 0; commit_late_fwb_i = 0; commit_rd_addr_i = 0;
        iwb_v_i = 0; iwb_late_i = 0; iwb_addr_i = 0;
        fwb_v_i = 0; fwb_late_i = 0; fwb_addr_i = 0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        idle_inputs();
    endtask

    task automatic commit(input logic i, input logic f, input logic [4:0] rd);
        commit_v_i = 1; commit_late_iwb_i = i; commit_late_fwb_i = f; commit_rd_addr_i = rd;
    endtask

    task automatic iwb(input logic late, input logic [4:0] a);
        iwb_v_i = 1; iwb_late_i = late; iwb_addr_i = a;
    endtask

    task automatic fwb(input logic late, input logic [4:0] a);
        fwb_v_i = 1; fwb_late_i = late; fwb_addr_i = a;
    endtask

    task automatic do_reset();
        freeze_i = 0;
        reset_i = 1;
        idle_inputs();
        step();
        step();
        reset_i = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ipending_o !== 32'h0) begin errors++; $display("FAIL reset_ipending: got %h want 0", ipending_o); end
        checks++; if (fpending_o !== 32'h0) begin errors++; $display("FAIL reset_fpending: got %h want 0", fpending_o); end
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b want 1", idle_o); end
        checks++; if (error_v_o !== 1'b0) begin errors++; $display("FAIL reset_err_v: got %b want 0", error_v_o); end
        checks++; if (error_code_o !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", error_code_o); end
        checks++; if (error_addr_o !== 6'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", error_addr_o); end
    endtask

    task automatic test_late_load();
        do_reset();
        commit(1, 0, 5'd5); step();
        for (int k = 1; k < 10; k++) begin
            checks++; if (ipending_o !== 32'h20) begin errors++; $display("FAIL load_pending_c%0d: got %h want 00000020", k, ipending_o); end
            step();
        end
        checks++; if (idle_o !== 1'b0) begin errors++; $display("FAIL load_busy: got %b want 0", idle_o); end
        iwb(1, 5'd5); step();
        checks++; if (ipending_o !== 32'h0) begin errors++; $display("FAIL load_clear: got %h want 0", ipending_o); end
        checks++; if (idle_o !== 1'b1) begin errors++; $display("FAIL load_idle: got %b want 1", idle_o); end
        // non-late write does not retire an outstanding entry
        commit(1, 0, 5'd6); step();
        iwb(0, 5'd6); step();
        checks++; if (ipending_o !== 32'h40) begin errors++; $display("FAIL nonlate_ignored: got %h want 00000040", ipending_o); end
        iwb(1, 5'd6); step();
        checks++; if (ipending_o !== 32'h0) begin errors++; $display("FAIL nonlate_clear: got %h want 0", ipending_o); end
        checks++; if (error_v_o !== 1'b0) begin errors++; $display("FAIL load_noerr: got %b want 0", error_v_o); end
    endtask

    task automatic test_x0_and_dual();
        do_reset();
        commit(1, 1, 5'd0); step();
        checks++; if (ipending_o !== 32'h0) begin errors++; $display("FAIL x0_ignored: got %h want 0", ipending_o); end
        checks++; if (fpending_o !== 32'h1) begin errors++; $display("FAIL f0_tracked: got %h want 00000001", fpending_o); end
        iwb(1, 5'd0); fwb(1, 5'd0); step();
        checks++; if ({error_v_o, fpending_o} !== 33'h0) begin errors++; $display("FAIL x0_wb_noerr: got %h want 0", {error_v_o, fpending_o}); end
        commit(1, 1, 5'd17); step();
        checks++; if ({ipending_o, fpending_o} !== {32'h20000, 32'h20000}) begin errors++; $display("FAIL dual_commit: got %h want 0002000000020000", {ipending_o, fpending_o}); end
    endtask

    task automatic test_underflow_fp();
        do_reset();
        fwb(1, 5'd3); step();
        checks++; if (error_v_o !== 1'b1) begin errors++; $display("FAIL uf_v: got %b want 1", error_v_o); end
        checks++; if (error_code_o !== 2'd1) begin errors++; $display("FAIL uf_code: got %0d want 1", error_code_o); end
        checks++; if (error_addr_o !== 6'h23) begin errors++; $display("FAIL uf_addr: got %h want 23", error_addr_o); end
        checks++; if (fpending_o !== 32'h0) begin errors++; $display("FAIL uf_fp3: got %h want 0", fpending_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k < 7; k++) begin commit(1, 0, 5'd7); step(); end
        checks++; if (error_v_o !== 1'b0) begin errors++; $display("FAIL of_early: got %b want 0", error_v_o); end
        commit(1, 0, 5'd7); step();
        checks++; if ({error_v_o, error_code_o, error_addr_o} !== {1'b1, 2'd2, 6'h07}) begin errors++; $display("FAIL of_err: got %b/%0d/%h want 1/2/07", error_v_o, error_code_o, error_addr_o); end
        // counter saturated at 7: six retires leave it pending, the seventh clears
        for (int k = 0; k < 6; k++) begin iwb(1, 5'd7); step(); end
        checks++; if (ipending_o !== 32'h80) begin errors++; $display("FAIL of_hold: got %h want 00000080", ipending_o); end
        iwb(1, 5'd7); step();
        checks++; if (ipending_o !== 32'h0) begin errors++; $display("FAIL of_drain: got %h want 0", ipending_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        commit(1, 0, 5'd9); step();
        commit(1, 0, 5'd9); iwb(1, 5'd9); step();
        checks++; if (ipending_o !== 32'h200) begin errors++; $display("FAIL b2b_hold: got %h want 00000200", ipending_o); end
        checks++; if (error_v_o !== 1'b0) begin errors++; $display("FAIL b2b_noerr: got %b want 0", error_v_o); end
        iwb(1, 5'd9); step();
        checks++; if (ipending_o !== 32'h0) begin errors++; $display("FAIL b2b_single: got %h want 0", ipending_o); end
    endtask

    task automatic test_timeout();
        do_reset();
        commit(1, 0, 5'd1); step();
        for (int k = 1; k < 16; k++) step();
        checks++; if (error_v_o !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", error_v_o); end
        step();
        checks++; if ({error_v_o, error_code_o, error_addr_o} !== {1'b1, 2'd3, 6'h0}) begin errors++; $display("FAIL to_err: got %b/%0d/%h want 1/3/00", error_v_o, error_code_o, error_addr_o); end
        // a writeback to another register restarts the age
        do_reset();
        commit(1, 0, 5'd1); step();
        commit(1, 0, 5'd2); step();
        for (int k = 2; k < 10; k++) step();
        iwb(1, 5'd2); step();
        for (int k = 11; k < 26; k++) step();
        checks++; if (error_v_o !== 1'b0) begin errors++; $display("FAIL to2_early: got %b want 0", error_v_o); end
        step();
        checks++; if ({error_v_o, error_code_o} !== {1'b1, 2'd3}) begin errors++; $display("FAIL to2_err: got %b/%0d want 1/3", error_v_o, error_code_o); end
        checks++; if (ipending_o !== 32'h2) begin errors++; $display("FAIL to2_pending: got %h want 00000002", ipending_o); end
    endtask

    task automatic test_priority_and_reset();
        do_reset();
        for (int k = 0; k < 7; k++) begin commit(0, 1, 5'd4); step(); end
        commit(0, 1, 5'd4); iwb(1, 5'd12); step();
        checks++; if ({error_v_o, error_code_o, error_addr_o} !== {1'b1, 2'd1, 6'h0c}) begin errors++; $display("FAIL prio: got %b/%0d/%h want 1/1/0c", error_v_o, error_code_o, error_addr_o); end
        reset_i = 1; step(); reset_i = 0;
        checks++; if ({ipending_o, fpending_o, idle_o, error_v_o, error_code_o, error_addr_o} !== {64'h0, 1'b1, 1'b0, 2'd0, 6'h0}) begin errors++; $display("FAIL midreset: got %h/%h/%b/%b/%0d/%h want 0/0/1/0/0/00", ipending_o, fpending_o, idle_o, error_v_o, error_code_o, error_addr_o); end
        // freeze discards outstanding work without a later timeout
        commit(1, 0, 5'd3); step();
        freeze_i = 1; step(); freeze_i = 0;
        checks++; if ({ipending_o, idle_o} !== {32'h0, 1'b1}) begin errors++; $display("FAIL freeze_clear: got %h/%b want 0/1", ipending_o, idle_o); end
        for (int k = 0; k < 20; k++) step();
        checks++; if (error_v_o !== 1'b0) begin errors++; $display("FAIL freeze_noerr: got %b want 0", error_v_o); end
    endtask

    initial begin
        freeze_i = 0;
        reset_i = 1;
        idle_inputs();
        test_reset();
        test_late_load();
        test_x0_and_dual();
        test_underflow_fp();
        test_overflow();
        test_back_to_back();
        test_timeout();
        test_priority_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
